// File: rtl/mux_rr_stream_pkg.sv
// Shared constants for the round-robin / fixed-select stream multiplexer.
// Mode encodings are shared by the top and the bench.
package mux_rr_stream_pkg;

    localparam logic MODE_RR    = 1'b0;
    localparam logic MODE_FIXED = 1'b1;

endpackage

// File: rtl/mux_rr_stream_rr_arbiter.sv
// Combinational rotating-priority arbiter.
// The search starts at ptr_i and wraps modulo N_CH.
module rr_arbiter #(
    parameter  int N_CH  = 8,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0]  req_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_CH-1:0]  gnt_o,
    output logic [SEL_W-1:0] gnt_idx_o,
    output logic             any_gnt_o
);

    int                c;
    logic [SEL_W-1:0]  idx;

    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = '0;
        any_gnt_o = 1'b0;
        c         = 0;
        idx       = '0;
        for (int k = 0; k < N_CH; k++) begin
            c = int'(ptr_i) + k;
            if (c >= N_CH) begin
                c = c - N_CH;
            end
            idx = SEL_W'(c);
            if (!any_gnt_o && req_i[idx]) begin
                any_gnt_o = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/mux_rr_stream.sv
// N-channel stream mux with registered output stage.
// Round-robin or fixed-select arbitration, one word per cycle.
module mux_rr_stream
    import mux_rr_stream_pkg::*;
#(
    parameter  int N_CH  = 8,
    parameter  int WIDTH = 1,
    localparam int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       in_valid,
    output logic [N_CH-1:0]       in_ready,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_ch
);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;

    logic             load;
    logic             xfer;
    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  gnt;
    logic [SEL_W-1:0] gnt_idx;
    logic             any_gnt;
    logic [WIDTH-1:0] data_arr [N_CH];
    logic [WIDTH-1:0] gnt_data;

    for (genvar i = 0; i < N_CH; i++) begin : g_split
        assign data_arr[i] = in_data[i*WIDTH +: WIDTH];
    end

    // In fixed mode only the selected channel may compete.
    always_comb begin
        elig = '0;
        if (mode == MODE_RR) begin
            elig = in_valid;
        end else if (int'(sel) < N_CH) begin
            elig[sel] = in_valid[sel];
        end
    end

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_arb (
        .req_i     (elig),
        .ptr_i     (ptr_q),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx),
        .any_gnt_o (any_gnt)
    );

    assign load     = !out_valid_q || out_ready;
    assign xfer     = load && any_gnt && rst_n;
    assign in_ready = gnt & {N_CH{load && rst_n}};
    assign gnt_data = data_arr[gnt_idx];

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        ptr_d       = ptr_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt_idx;
            if (mode == MODE_RR) begin
                ptr_d = (gnt_idx == SEL_W'(N_CH-1)) ? '0 : gnt_idx + 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_mux_rr_stream.sv
// Self-checking bench for mux_rr_stream.
// Directed scenarios plus random traffic against a behavioural model.
module tb_mux_rr_stream;

    localparam int N = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mode = 1'b0;
    logic [2:0] sel = '0;
    logic [7:0] in_valid = '0;
    logic [7:0] in_ready;
    logic [7:0] in_data = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [0:0] out_data;
    logic [2:0] out_ch;

    int vectors = 0;
    int miscompares = 0;

    bit m_ov;
    bit m_od;
    int m_och;
    int m_ptr;

    mux_rr_stream #(.N_CH(8), .WIDTH(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ch    (out_ch)
    );

    always #5 clk = ~clk;

    // Expected one-hot acceptance for the current inputs and model state.
    function automatic logic [7:0] m_grant();
        logic [7:0] g;
        logic [2:0] c3;
        g = '0;
        if (!rst_n) return g;
        if (m_ov && !out_ready) return g;
        if (mode) begin
            if (in_valid[sel]) g[sel] = 1'b1;
            return g;
        end
        for (int k = 0; k < N; k++) begin
            c3 = 3'((m_ptr + k) % N);
            if (in_valid[c3]) begin
                g[c3] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic m_reset();
        m_ov = 0;
        m_od = 0;
        m_och = 0;
        m_ptr = 0;
    endtask

    task automatic tick();
        logic [7:0] g;
        logic [2:0] c3;
        g = m_grant();
        for (int c = 0; c < N; c++) begin
            c3 = 3'(c);
            if (g[c3]) begin
                m_od = in_data[c3];
                m_och = c;
                m_ov = 1;
                if (!mode) m_ptr = (c + 1) % N;
            end
        end
        if (g == 0 && m_ov && out_ready) m_ov = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        m_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        in_valid = 8'hFF;
        out_ready = 1'b1;
        m_reset();
        #2;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== 1'b0 || out_ch !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_out: got v=%0b d=%0b ch=%0d want 0 0 0",
                     out_valid, out_data, out_ch);
        end
        vectors++;
        if (in_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ready: got %h want 00", in_ready);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_hold: got v=%0b rdy=%h want 0 00",
                     out_valid, in_ready);
        end
        rst_n = 1'b1;
        in_valid = '0;
    endtask

    task automatic test_fixed_basic();
        mode = 1'b1;
        sel = 3'd2;
        in_valid = 8'h04;
        in_data = 8'h04;
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 8'h04) begin
            miscompares++;
            $display("FAIL fixed_basic_ready: got %h want 04", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_data !== 1'b1 || out_ch !== 3'd2) begin
            miscompares++;
            $display("FAIL fixed_basic_out: got v=%0b d=%0b ch=%0d want 1 1 2",
                     out_valid, out_data, out_ch);
        end
        in_valid = '0;
    endtask

    task automatic test_fixed_sweep();
        logic [7:0] one;
        logic       d;
        mode = 1'b1;
        out_ready = 1'b1;
        for (int s = 0; s < N; s++) begin
            sel = 3'(s);
            one = 8'h01 << s;
            in_valid = one;
            in_data = 8'($urandom);
            d = in_data[sel];
            #1;
            vectors++;
            if (in_ready !== one) begin
                miscompares++;
                $display("FAIL sweep_ready sel=%0d: got %h want %h", s, in_ready, one);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== 3'(s) || out_data !== d) begin
                miscompares++;
                $display("FAIL sweep_out sel=%0d: got v=%0b ch=%0d d=%0b want 1 %0d %0b",
                         s, out_valid, out_ch, out_data, s, d);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_rr_wrap();
        logic [7:0] one;
        mode = 1'b0;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_data = 8'($urandom);
            one = 8'h01 << (k % N);
            #1;
            vectors++;
            if (in_ready !== one) begin
                miscompares++;
                $display("FAIL rr_wrap_ready k=%0d: got %h want %h", k, in_ready, one);
            end
            tick();
            vectors++;
            if (out_ch !== 3'(k % N) || out_data !== m_od || out_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_wrap_out k=%0d: got ch=%0d d=%0b want %0d %0b",
                         k, out_ch, out_data, k % N, m_od);
            end
        end
        in_valid = '0;
    endtask

    task automatic test_rr_backpressure();
        logic [7:0] want;
        logic [2:0] snap_ch;
        logic       snap_d;
        do_reset();
        mode = 1'b0;
        in_valid = 8'h81;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_data = 8'($urandom);
            want = (k % 2 == 1) ? 8'h80 : 8'h01;
            #1;
            vectors++;
            if (in_ready !== want) begin
                miscompares++;
                $display("FAIL bp_ready k=%0d: got %h want %h", k, in_ready, want);
            end
            tick();
            vectors++;
            if (out_ch !== ((k % 2 == 1) ? 3'd7 : 3'd0)) begin
                miscompares++;
                $display("FAIL bp_grant k=%0d: got ch=%0d want %0d",
                         k, out_ch, (k % 2 == 1) ? 7 : 0);
            end
        end
        out_ready = 1'b0;
        snap_ch = out_ch;
        snap_d = out_data;
        for (int k = 0; k < 3; k++) begin
            in_data = 8'($urandom);
            #1;
            vectors++;
            if (in_ready !== 8'h00) begin
                miscompares++;
                $display("FAIL bp_stall_ready k=%0d: got %h want 00", k, in_ready);
            end
            tick();
            vectors++;
            if (out_valid !== 1'b1 || out_ch !== snap_ch || out_data !== snap_d) begin
                miscompares++;
                $display("FAIL bp_stall_out k=%0d: got v=%0b ch=%0d d=%0b want 1 %0d %0b",
                         k, out_valid, out_ch, out_data, snap_ch, snap_d);
            end
        end
        out_ready = 1'b1;
        in_valid = '0;
        tick();
    endtask

    task automatic test_mode_switch();
        logic       d;
        logic [7:0] want;
        int         p;
        mode = 1'b1;
        sel = 3'd3;
        in_valid = 8'h08;
        in_data = 8'($urandom);
        d = in_data[3];
        out_ready = 1'b1;
        #1;
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_data !== d) begin
            miscompares++;
            $display("FAIL switch_fixed: got v=%0b ch=%0d d=%0b want 1 3 %0b",
                     out_valid, out_ch, out_data, d);
        end
        out_ready = 1'b0;
        mode = 1'b0;
        in_valid = 8'hFF;
        in_data = ~in_data;
        #1;
        vectors++;
        if (in_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL switch_stall_ready: got %h want 00", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 3'd3 || out_data !== d) begin
            miscompares++;
            $display("FAIL switch_held: got v=%0b ch=%0d d=%0b want 1 3 %0b",
                     out_valid, out_ch, out_data, d);
        end
        out_ready = 1'b1;
        p = m_ptr;
        want = 8'h01 << p;
        #1;
        vectors++;
        if (in_ready !== want) begin
            miscompares++;
            $display("FAIL switch_rr_ready: got %h want %h", in_ready, want);
        end
        tick();
        vectors++;
        if (out_ch !== 3'(p) || out_data !== m_od) begin
            miscompares++;
            $display("FAIL switch_rr_out: got ch=%0d d=%0b want %0d %0b",
                     out_ch, out_data, p, m_od);
        end
        in_valid = '0;
    endtask

    task automatic test_async_reset();
        mode = 1'b0;
        in_valid = 8'hFF;
        out_ready = 1'b1;
        in_data = 8'($urandom);
        tick();
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL areset_pre: got v=%0b want 1", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_ch !== 3'd0 || in_ready !== 8'h00) begin
            miscompares++;
            $display("FAIL areset_now: got v=%0b ch=%0d rdy=%h want 0 0 00",
                     out_valid, out_ch, in_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 8'h01) begin
            miscompares++;
            $display("FAIL areset_first_ready: got %h want 01", in_ready);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_ch !== 3'd0) begin
            miscompares++;
            $display("FAIL areset_first_out: got v=%0b ch=%0d want 1 0",
                     out_valid, out_ch);
        end
    endtask

    task automatic test_random();
        logic [7:0] want;
        for (int k = 0; k < 400; k++) begin
            mode = ($urandom_range(0, 3) == 0);
            sel = 3'($urandom);
            in_valid = 8'($urandom);
            in_data = 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            want = m_grant();
            vectors++;
            if (in_ready !== want) begin
                miscompares++;
                $display("FAIL rand_ready k=%0d: got %h want %h", k, in_ready, want);
            end
            tick();
            vectors++;
            if (out_valid !== m_ov || out_ch !== 3'(m_och) || out_data !== m_od) begin
                miscompares++;
                $display("FAIL rand_out k=%0d: got v=%0b ch=%0d d=%0b want %0b %0d %0b",
                         k, out_valid, out_ch, out_data, m_ov, m_och, m_od);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_basic();
        test_fixed_sweep();
        test_rr_wrap();
        test_rr_backpressure();
        test_mode_switch();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
